// File: rtl/tone_if.sv
// tone_if: request/grant handshake and tune bus between requesters and the tone scheduler
// Ports: en, req[2:0] toward the scheduler; grant/done/abort[2:0], tune[4:0], tune_en back
interface tone_if;
  logic en;
  logic [2:0] req;
  logic [2:0] grant;
  logic [2:0] done;
  logic [2:0] abort;
  logic [4:0] tune;
  logic tune_en;
  modport master(output en, req, input grant, done, abort, tune, tune_en);
  modport slave(input en, req, output grant, done, abort, tune, tune_en);
endinterface

// File: rtl/tone_scheduler.sv
// tone_scheduler: shares one beep generator between click, scale and alarm note patterns
// Ports: clk16Hz tick clock, rst async active-high reset,
//   bus.en flush-to-idle when low, bus.req rising-edge requests [0]click [1]scale [2]alarm,
//   bus.grant one-hot owner, bus.done/bus.abort 1-tick pulses, bus.tune/bus.tune_en to beep datapath
module tone_scheduler #(
  parameter int NOTE_LEN = 4,
  parameter int GAP_LEN = 1,
  parameter int CLICK_LEN = 2,
  parameter int ALARM_REPS = 4
) (
  input logic clk16Hz,
  input logic rst,
  tone_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PLAY, GAP, FIN} state_t;
  localparam logic [7:0] NL = 8'(NOTE_LEN);
  localparam logic [7:0] GL = 8'(GAP_LEN);
  localparam logic [7:0] CL = 8'(CLICK_LEN);
  localparam logic [4:0] AL = 5'(2 * ALARM_REPS - 1);
  state_t state, state_n;
  logic [2:0] pending, pend_n, req_d, reqd_n, grant, grant_n, done, done_n, abort, abort_n;
  logic [7:0] tick, tick_n, len;
  logic [4:0] idx, idx_n, last, tune, tune_n;
  logic [2:0] clr;
  function automatic logic [4:0] note(input logic [2:0] g, input logic [4:0] i);
    return g[2] ? (i[0] ? 5'd12 : 5'd19) : g[1] ? i + 5'd1 : 5'd15;
  endfunction
  assign len = grant[0] ? CL : NL;
  assign last = grant[2] ? AL : grant[1] ? 5'd6 : 5'd0;
  always_comb begin
    state_n = state;
    grant_n = grant;
    done_n = '0;
    abort_n = '0;
    tick_n = tick;
    idx_n = idx;
    clr = '0;
    reqd_n = bus.req;
    case (state)
      IDLE:
        if (|pending) begin
          grant_n = pending[2] ? 3'b100 : pending[1] ? 3'b010 : 3'b001;
          clr = grant_n;
          tick_n = '0;
          idx_n = '0;
          state_n = PLAY;
        end
      PLAY, GAP:
        if (pending[2] && !grant[2]) begin
          abort_n = grant;
          grant_n = '0;
          tick_n = '0;
          idx_n = '0;
          state_n = FIN;
        end else if (state == PLAY) begin
          if (tick == len - 8'd1) begin
            tick_n = '0;
            if (idx == last) begin
              done_n = grant;
              grant_n = '0;
              idx_n = '0;
              state_n = FIN;
            end else if (GAP_LEN > 0) state_n = GAP;
            else idx_n = idx + 5'd1;
          end else tick_n = tick + 8'd1;
        end else if (tick == GL - 8'd1) begin
          tick_n = '0;
          idx_n = idx + 5'd1;
          state_n = PLAY;
        end else tick_n = tick + 8'd1;
      default: state_n = IDLE;
    endcase
    pend_n = (pending & ~clr) | (bus.req & ~req_d);
    if (!bus.en) begin
      state_n = IDLE;
      grant_n = '0;
      done_n = '0;
      abort_n = '0;
      tick_n = '0;
      idx_n = '0;
      pend_n = '0;
      reqd_n = '0;
    end
    tune_n = (state_n == PLAY) ? note(grant_n, idx_n) : '0;
  end
  always_ff @(posedge clk16Hz or posedge rst)
    if (rst) begin
      state <= IDLE;
      pending <= '0;
      req_d <= '0;
      grant <= '0;
      done <= '0;
      abort <= '0;
      tick <= '0;
      idx <= '0;
      tune <= '0;
      bus.tune_en <= 1'b0;
    end else begin
      state <= state_n;
      pending <= pend_n;
      req_d <= reqd_n;
      grant <= grant_n;
      done <= done_n;
      abort <= abort_n;
      tick <= tick_n;
      idx <= idx_n;
      tune <= tune_n;
      bus.tune_en <= (state_n == PLAY);
    end
  assign bus.grant = grant;
  assign bus.done = done;
  assign bus.abort = abort;
  assign bus.tune = tune;
endmodule

// File: tb/tb_tone_scheduler.sv
// tb_tone_scheduler: directed and random scenarios checked against a note-schedule model
module tb_tone_scheduler;
  localparam int NOTE_LEN = 4, GAP_LEN = 1, CLICK_LEN = 2, ALARM_REPS = 4;
  logic clk16Hz = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  tone_if bus();
  tone_scheduler #(.NOTE_LEN(NOTE_LEN), .GAP_LEN(GAP_LEN), .CLICK_LEN(CLICK_LEN),
    .ALARM_REPS(ALARM_REPS)) dut (.clk16Hz(clk16Hz), .rst(rst), .bus(bus));
  always #5 clk16Hz = ~clk16Hz;

  // Model: a job is expanded into the list of tune values it sounds, one per tick
  // (0 = silent gap); afterwards a single FIN tick and an IDLE tick follow.
  int m_phase;  // 0 idle, 1 playing, 2 fin
  logic [2:0] m_pend, m_reqd, m_grant, m_done, m_abort;
  logic [4:0] m_tune;
  int q[$];

  function automatic logic [14:0] obs();
    return {bus.grant, bus.done, bus.abort, bus.tune, bus.tune_en};
  endfunction
  function automatic logic [14:0] expv();
    return {m_grant, m_done, m_abort, m_tune, m_tune != 5'd0};
  endfunction

  task automatic model_clear();
    m_phase = 0; m_pend = 0; m_reqd = 0; m_grant = 0; m_done = 0; m_abort = 0; m_tune = 0;
    q.delete();
  endtask

  task automatic build(input int job);
    q.delete();
    if (job == 0) for (int k = 0; k < CLICK_LEN; k++) q.push_back(15);
    else begin
      int n = (job == 1) ? 7 : 2 * ALARM_REPS;
      for (int j = 0; j < n; j++) begin
        int v = (job == 1) ? j + 1 : ((j % 2 == 0) ? 19 : 12);
        if (j > 0) for (int k = 0; k < GAP_LEN; k++) q.push_back(0);
        for (int k = 0; k < NOTE_LEN; k++) q.push_back(v);
      end
    end
  endtask

  task automatic model_step();
    logic [2:0] rise;
    if (rst || !bus.en) begin model_clear(); return; end
    rise = bus.req & ~m_reqd;
    m_done = 0; m_abort = 0;
    if (m_phase == 2) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (m_pend != 0) begin
        int i = m_pend[2] ? 2 : m_pend[1] ? 1 : 0;
        m_pend[i] = 1'b0;
        build(i);
        m_grant = 3'(1 << i);
        m_tune = 5'(q.pop_front());
        m_phase = 1;
      end
    end else if ((m_pend[2] && !m_grant[2]) || q.size() == 0) begin
      if (q.size() != 0 || (m_pend[2] && !m_grant[2])) m_abort = m_grant;
      else m_done = m_grant;
      m_grant = 0; m_tune = 0; m_phase = 2; q.delete();
    end else m_tune = 5'(q.pop_front());
    m_pend |= rise;
    m_reqd = bus.req;
  endtask

  task automatic tick();
    @(posedge clk16Hz);
    model_step();
    @(negedge clk16Hz);
  endtask

  task automatic test_reset();
    model_clear();
    bus.en = 1'b1; bus.req = 3'b000;
    repeat (2) @(negedge clk16Hz);
    checks++;
    if (obs() !== 15'd0) begin fails++; $display("FAIL reset got %h exp 0", obs()); end
    rst = 1'b0;
  endtask

  task automatic test_click();
    bus.req = 3'b001;
    tick();
    bus.req = 3'b000;
    tick();
    checks++;
    if (bus.grant !== 3'b001 || bus.tune !== 5'd15 || bus.tune_en !== 1'b1) begin
      fails++; $display("FAIL click_start got g=%b t=%0d e=%b exp g=001 t=15 e=1", bus.grant, bus.tune, bus.tune_en);
    end
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin fails++; $display("FAIL click t=%0d got %h exp %h", t, obs(), expv()); end
    end
  endtask

  task automatic test_scale();
    int granted = 0;
    logic [2:0] dseen = 0;
    bus.req = 3'b010;
    tick();
    bus.req = 3'b000;
    for (int t = 0; t < 42; t++) begin
      tick();
      if (bus.grant == 3'b010) granted++;
      dseen |= bus.done;
      checks++;
      if (obs() !== expv()) begin fails++; $display("FAIL scale t=%0d got %h exp %h", t, obs(), expv()); end
    end
    checks++;
    if (granted != 34 || dseen !== 3'b010) begin
      fails++; $display("FAIL scale_len got %0d ticks done=%b exp 34 ticks done=010", granted, dseen);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] d1 = 0, d2 = 0;
    bus.req = 3'b011;
    tick();
    bus.req = 3'b000;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (bus.done != 0) begin if (d1 == 0) d1 = bus.done; else d2 = bus.done; end
      checks++;
      if (obs() !== expv()) begin fails++; $display("FAIL simul t=%0d got %h exp %h", t, obs(), expv()); end
    end
    checks++;
    if ({d1, d2} !== 6'b010_001) begin fails++; $display("FAIL simul_order got %b,%b exp 010,001", d1, d2); end
  endtask

  task automatic test_preempt();
    int found = 0, restarts = 0;
    logic [2:0] ab = 0, dn = 0, pg = 0;
    bus.req = 3'b010;
    tick();
    bus.req = 3'b000;
    for (int t = 0; t < 40 && found == 0; t++) begin
      tick();
      if (bus.tune == 5'd3) found = 1;
    end
    checks++;
    if (found == 0) begin fails++; $display("FAIL preempt_note3 got none exp tune=3"); end
    bus.req = 3'b100;
    tick();
    bus.req = 3'b000;
    for (int t = 0; t < 70; t++) begin
      tick();
      ab |= bus.abort; dn |= bus.done;
      if (ab != 0 && bus.grant == 3'b010 && pg != 3'b010) restarts++;
      pg = bus.grant;
      checks++;
      if (obs() !== expv()) begin fails++; $display("FAIL preempt t=%0d got %h exp %h", t, obs(), expv()); end
    end
    checks++;
    if (ab !== 3'b010 || dn !== 3'b100 || restarts != 0) begin
      fails++; $display("FAIL preempt_result got abort=%b done=%b replays=%0d exp 010 100 0", ab, dn, restarts);
    end
  endtask

  task automatic test_flush();
    bus.req = 3'b100;
    tick();
    bus.req = 3'b000;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    model_clear();
    checks++;
    if (obs() !== 15'd0) begin fails++; $display("FAIL async_rst got %h exp 0", obs()); end
    @(negedge clk16Hz);
    rst = 1'b0;
    bus.req = 3'b010;
    tick();
    bus.req = 3'b001;
    repeat (6) tick();
    bus.req = 3'b000;
    bus.en = 1'b0;
    tick();
    checks++;
    if (obs() !== 15'd0) begin fails++; $display("FAIL en_flush got %h exp 0", obs()); end
    bus.en = 1'b1;
    for (int t = 0; t < 15; t++) begin
      tick();
      checks++;
      if (bus.grant !== 3'b000 || obs() !== expv()) begin
        fails++; $display("FAIL pend_lost t=%0d got %h exp %h", t, obs(), expv());
      end
    end
  endtask

  task automatic test_level();
    int starts = 0;
    logic [2:0] pg = 0;
    bus.req = 3'b010;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (bus.grant == 3'b010 && pg != 3'b010) starts++;
      pg = bus.grant;
    end
    checks++;
    if (starts != 1) begin fails++; $display("FAIL level_once got %0d exp 1", starts); end
    starts = 0;
    bus.req = 3'b000;
    repeat (3) tick();
    bus.req = 3'b010;
    for (int t = 0; t < 95; t++) begin
      if (t == 10) bus.req = 3'b000;
      if (t == 13) bus.req = 3'b010;
      tick();
      if (bus.grant == 3'b010 && pg != 3'b010) starts++;
      pg = bus.grant;
      checks++;
      if (obs() !== expv()) begin fails++; $display("FAIL level t=%0d got %h exp %h", t, obs(), expv()); end
    end
    bus.req = 3'b000;
    checks++;
    if (starts != 2) begin fails++; $display("FAIL replay got %0d starts exp 2", starts); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      bus.req = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      bus.en = ($urandom_range(0, 79) != 0);
      tick();
      checks++;
      if (obs() !== expv()) begin fails++; $display("FAIL random t=%0d got %h exp %h", t, obs(), expv()); end
    end
    bus.en = 1'b1; bus.req = 3'b000;
  endtask

  initial begin
    test_reset();
    test_click();
    test_scale();
    test_simultaneous();
    test_preempt();
    test_flush();
    test_level();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
